aes_sub_bytes_seq: RTL and testbench

Sequential AES SubBytes engine for the encryption datapath of the CRC-secured link. Accepts a 128-bit state block over a valid/ready handshake and substitutes every byte through the forward composite-field S-box, LANES bytes per cycle. Presents the substituted block on a second valid/ready handshake to the ShiftRows stage. It is the encrypt-side counterpart of the inverse S-box used on the decrypt path.

---
 rtl/aes_pkg.sv | 103 ++++++++++
 rtl/S_Sbox.sv | 21 ++
 rtl/aes_sub_bytes_seq.sv | 71 +++++++
 tb/tb_aes_sub_bytes_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, sizes, and composite-field GF((2^4)^2) arithmetic.
// Isomorphic maps are derived at elaboration from a root of the AES polynomial, so they stay consistent with GF_LAMBDA.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   localparam int         BYTE_W      = 8;
   localparam int         BLOCK_BYTES = 16;
   localparam logic [7:0] AFFINE_C    = 8'h63;
   // GF(2^4) is mod x^4+x+1; the extension is y^2+y+lambda, irreducible because Tr(0xC)=1
   localparam logic [3:0] GF_LAMBDA   = 4'hC;

   function automatic logic [3:0] gf4_mul(logic [3:0] a, logic [3:0] b);
      logic [3:0] p;
      logic [3:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p ^= t;
         t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
      end
      return p;
   endfunction

   function automatic logic [3:0] gf4_sq(logic [3:0] a);
      return gf4_mul(a, a);
   endfunction

   // a^-1 = a^14 in GF(16); maps 0 to 0 for free
   function automatic logic [3:0] gf4_inv(logic [3:0] a);
      logic [3:0] a2, a4, a8;
      a2 = gf4_sq(a);
      a4 = gf4_sq(a2);
      a8 = gf4_sq(a4);
      return gf4_mul(gf4_mul(a8, a4), a2);
   endfunction

   function automatic logic [7:0] gf8c_mul(logic [7:0] a, logic [7:0] b);
      logic [3:0] hh;
      hh = gf4_mul(a[7:4], b[7:4]);
      return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
              gf4_mul(hh, GF_LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
   endfunction

   function automatic logic [7:0] find_beta();
      logic [7:0] beta, p, acc;
      logic       found;
      beta  = 8'h00;
      found = 1'b0;
      for (int c = 2; c < 256; c++) begin
         p   = 8'h01;
         acc = 8'h01;
         for (int k = 1; k <= 8; k++) begin
            p = gf8c_mul(p, 8'(c));
            if (k == 1 || k == 3 || k == 4 || k == 8) acc ^= p;
         end
         if (!found && acc == 8'h00) begin
            beta  = 8'(c);
            found = 1'b1;
         end
      end
      return beta;
   endfunction

   function automatic logic [7:0] lin_apply(logic [7:0][7:0] m, logic [7:0] a);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (a[i]) r ^= m[i];
      return r;
   endfunction

   // column i is the image of x^i, i.e. beta^i
   function automatic logic [7:0][7:0] iso_map();
      logic [7:0][7:0] m;
      logic [7:0]      beta;
      beta = find_beta();
      m[0] = 8'h01;
      for (int i = 1; i < 8; i++) m[i] = gf8c_mul(m[i-1], beta);
      return m;
   endfunction

   function automatic logic [7:0][7:0] inv_iso_map();
      logic [7:0][7:0] m, r;
      m = iso_map();
      r = '0;
      for (int j = 0; j < 8; j++)
         for (int a = 0; a < 256; a++)
            if (lin_apply(m, 8'(a)) == 8'(1 << j)) r[j] = 8'(a);
      return r;
   endfunction

   localparam logic [7:0][7:0] ISO_MAP     = iso_map();
   localparam logic [7:0][7:0] INV_ISO_MAP = inv_iso_map();

   function automatic logic [7:0] affine(logic [7:0] s);
      logic [7:0] b;
      for (int i = 0; i < 8; i++)
         b[i] = s[i] ^ s[(i+4)%8] ^ s[(i+5)%8] ^ s[(i+6)%8] ^ s[(i+7)%8] ^ AFFINE_C[i];
      return b;
   endfunction

endpackage

// File: rtl/S_Sbox.sv
// Forward AES S-box, composite field: map in, GF((2^4)^2) inverse, map out, affine.
module S_Sbox
   import aes_pkg::*;
(
   input  logic [7:0] x,
   output logic [7:0] y
);

   logic [7:0] q, qi;
   logic [3:0] ah, al, d, di;

   assign q  = lin_apply(ISO_MAP, x);
   assign ah = q[7:4];
   assign al = q[3:0];
   // norm of (ah*y + al); inverse is (ah*y + ah+al) / norm
   assign d  = gf4_mul(gf4_sq(ah), GF_LAMBDA) ^ gf4_mul(ah, al) ^ gf4_sq(al);
   assign di = gf4_inv(d);
   assign qi = {gf4_mul(ah, di), gf4_mul(ah ^ al, di)};
   assign y  = affine(lin_apply(INV_ISO_MAP, qi));

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential SubBytes: one 128-bit block in, LANES bytes substituted per cycle, block out.
module aes_sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int N    = BLOCK_BYTES / LANES;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   state_t                                 state, state_nx;
   logic [IDXW-1:0]                        idx;
   logic [BLOCK_BYTES-1:0][BYTE_W-1:0]     st;
   logic [LANES-1:0][BYTE_W-1:0]           sb_in, sb_out;
   logic                                   last;

   assign last = (32'(idx) == 32'(N - 1));

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign sb_in[l] = st[4'(32'(idx) * LANES + l)];
      S_Sbox u_sbox (.x(sb_in[l]), .y(sb_out[l]));
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = SUB;
         SUB:     if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         st    <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (in_valid) begin
               st  <= in_data;
               idx <= '0;
            end
            SUB: begin
               for (int l = 0; l < LANES; l++)
                  st[4'(32'(idx) * LANES + l)] <= sb_out[l];
               if (!last) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = st;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed and random checks of aes_sub_bytes_seq across LANES = 1, 2, 4, 8, 16.
module tb_aes_sub_bytes_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [5];
   logic         out_ready [5];
   logic [127:0] in_data   [5];
   logic         in_ready  [5];
   logic         out_valid [5];
   logic         busy      [5];
   logic [127:0] out_data  [5];

   int nvec = 0;
   int nerr = 0;
   int nacc = 0;
   int nout = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      aes_sub_bytes_seq #(.LANES(1 << g)) u_dut (
         .clk(clk), .rst(rst),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
         .busy(busy[g])
      );
   end

   // accept/complete tally for the LANES=4 instance
   always @(posedge clk) begin
      if (!rst) begin
         if (in_valid[2] && in_ready[2]) nacc++;
         if (out_valid[2] && out_ready[2]) nout++;
      end
   end

   localparam logic [127:0] SB_ROWS [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sref(logic [7:0] x);
      logic [127:0] row;
      row = SB_ROWS[x[7:4]];
      return row[127 - 8*x[3:0] -: 8];
   endfunction

   function automatic logic [127:0] block_ref(logic [127:0] d);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = sref(d[8*k +: 8]);
      return r;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(int i, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!out_valid[i] && cnt < 60);
   endtask

   task automatic run_block(int i, logic [127:0] din, logic [127:0] dexp, string tag);
      int cnt;
      chk($sformatf("%s in_ready", tag), 128'(in_ready[i]), 128'd1);
      in_valid[i] = 1'b1;
      in_data[i]  = din;
      tick();
      in_valid[i] = 1'b0;
      in_data[i]  = ~din;
      chk($sformatf("%s busy", tag), 128'(busy[i]), 128'd1);
      wait_out(i, cnt);
      chk($sformatf("%s latency", tag), 128'(cnt), 128'(16 >> i));
      chk($sformatf("%s data", tag), out_data[i], dexp);
      out_ready[i] = 1'b1;
      tick();
      out_ready[i] = 1'b0;
      chk($sformatf("%s out_valid drop", tag), 128'(out_valid[i]), 128'd0);
      chk($sformatf("%s in_ready back", tag), 128'(in_ready[i]), 128'd1);
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
      string        name;
   } vec_t;

   localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
   localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

   initial begin
      vec_t         tbl [3];
      int           cnt, seen;
      logic [127:0] din, dexp;
      bit           done;

      tbl[0] = '{128'h0, {16{8'h63}}, "zeros"};
      tbl[1] = '{FIPS_IN, FIPS_OUT, "fips197"};
      tbl[2] = '{{4{32'h00ff5301}}, {4{32'h6316ed7c}}, "edge_bytes"};

      for (int i = 0; i < 5; i++) begin
         in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = '0;
      end
      rst = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rst in_ready L%0d", 1 << i), 128'(in_ready[i]), 128'd0);
         chk($sformatf("rst out_valid L%0d", 1 << i), 128'(out_valid[i]), 128'd0);
         chk($sformatf("rst busy L%0d", 1 << i), 128'(busy[i]), 128'd0);
         chk($sformatf("rst out_data L%0d", 1 << i), out_data[i], 128'd0);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 5; i++)
         chk($sformatf("post-rst in_ready L%0d", 1 << i), 128'(in_ready[i]), 128'd1);

      for (int i = 0; i < 5; i++)
         for (int v = 0; v < 3; v++)
            run_block(i, tbl[v].din, tbl[v].dout, $sformatf("%s L%0d", tbl[v].name, 1 << i));

      // backpressure on LANES=4, with a second in_valid that must be ignored
      in_valid[2] = 1'b1;
      in_data[2]  = FIPS_IN;
      tick();
      in_valid[2] = 1'b0;
      wait_out(2, cnt);
      chk("bp latency", 128'(cnt), 128'd4);
      for (int c = 0; c < 10; c++) begin
         in_valid[2] = 1'b1;
         in_data[2]  = 128'h0;
         tick();
         chk($sformatf("bp hold out_valid c%0d", c), 128'(out_valid[2]), 128'd1);
         chk($sformatf("bp hold data c%0d", c), out_data[2], FIPS_OUT);
         chk($sformatf("bp hold in_ready c%0d", c), 128'(in_ready[2]), 128'd0);
      end
      in_valid[2]  = 1'b0;
      out_ready[2] = 1'b1;
      tick();
      out_ready[2] = 1'b0;
      chk("bp release out_valid", 128'(out_valid[2]), 128'd0);
      chk("bp release in_ready", 128'(in_ready[2]), 128'd1);
      chk("bp release busy", 128'(busy[2]), 128'd0);

      // reset in mid-SUB with LANES=1, then a clean block
      in_valid[0] = 1'b1;
      in_data[0]  = FIPS_IN;
      tick();
      in_valid[0] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("midrst in_ready", 128'(in_ready[0]), 128'd0);
      chk("midrst busy", 128'(busy[0]), 128'd0);
      chk("midrst out_valid", 128'(out_valid[0]), 128'd0);
      chk("midrst out_data", out_data[0], 128'd0);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (out_valid[0]) seen++;
      end
      chk("midrst no output", 128'(seen), 128'd0);
      run_block(0, FIPS_IN, FIPS_OUT, "after midrst L1");

      // random regression on LANES=4
      for (int b = 0; b < 1000; b++) begin
         repeat ($urandom_range(0, 2)) tick();
         din  = {$urandom, $urandom, $urandom, $urandom};
         dexp = block_ref(din);
         in_valid[2] = 1'b1;
         in_data[2]  = din;
         tick();
         in_valid[2] = 1'b0;
         in_data[2]  = {$urandom, $urandom, $urandom, $urandom};
         done = 1'b0;
         for (int c = 0; c < 60 && !done; c++) begin
            if (out_valid[2] && $urandom_range(0, 1) == 1) begin
               chk($sformatf("rand blk %0d", b), out_data[2], dexp);
               out_ready[2] = 1'b1;
               tick();
               out_ready[2] = 1'b0;
               done = 1'b1;
            end else begin
               tick();
            end
         end
         if (!done) chk($sformatf("rand blk %0d timeout", b), 128'd0, 128'd1);
      end
      chk("one output per accept", 128'(nout), 128'(nacc));
      chk("accept count", 128'(nacc), 128'd1001 + 128'd3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
